// File: rtl/frame_streamer_pkg.sv
// img_pkg: image geometry defaults, pixel/tag types and streamer FSM states
package img_pkg;
    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;
    localparam int DEF_PIX_W = 8;

    typedef logic [DEF_PIX_W-1:0] pixel_t;

    typedef struct packed {
        logic   sof;
        logic   eol;
        logic   eof;
        pixel_t data;
    } pix_tag_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/frame_streamer_if.sv
// frame_streamer_if: valid/ready pixel stream with frame and line markers
interface frame_streamer_if;
    import img_pkg::*;
    logic   valid;
    logic   ready;
    pixel_t data;
    logic   sof;
    logic   eol;
    logic   eof;
    modport master(output valid, data, sof, eol, eof, input ready);
    modport slave(input valid, data, sof, eol, eof, output ready);
endinterface

// File: rtl/frame_streamer_fifo.sv
// skid_fifo2: two-entry FIFO of tagged pixels with a registered head as output
module skid_fifo2
    import img_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  pix_tag_t   din,
    output pix_tag_t   dout,
    output logic [1:0] count
);
    pix_tag_t tail;

    // dout is the oldest entry; tail only fills while the head is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (pop)
                dout <= (count == 2'd2) ? tail : (push ? din : '0);
            else if (push && count == 2'd0)
                dout <= din;
            if (push && count == (pop ? 2'd2 : 2'd1))
                tail <= din;
        end
    end
endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: reads a stored frame from pixel RAM and streams it with sof/eol/eof markers
module frame_streamer
    import img_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    frame_streamer_if.master  m
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);

    state_t        state, state_nx;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          inflight;
    logic [2:0]    tag_q;
    logic [1:0]    count;
    logic          pop;
    logic          eol_x;
    pix_tag_t      din;
    pix_tag_t      head;

    assign pop     = m.valid & m.ready;
    assign eol_x   = x == XW'(IMG_W - 1);
    assign busy    = state != IDLE;
    assign m.valid = count != 2'd0;
    assign {m.sof, m.eol, m.eof, m.data} = head;
    assign din     = {tag_q, pixel_t'(mem_rd_data)};

    // read only while the FIFO plus the read in flight leaves room; leave DRAIN once the last pixel pops
    always_comb begin
        mem_rd_en = (state == RUN) && (({1'b0, count} + 3'(inflight) - 3'(pop)) < 3'd2);
        state_nx  = state;
        if (state == IDLE && start && !done)
            state_nx = RUN;
        if (state == RUN && mem_rd_en && mem_addr == LAST)
            state_nx = DRAIN;
        if (state == DRAIN && count == 2'(pop) && !inflight)
            state_nx = IDLE;
    end

    // state register and the one-cycle done pulse on return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == DRAIN) && (state_nx == IDLE);
        end
    end

    // address and raster counters; markers travel one cycle with the read they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            tag_q    <= '0;
            mem_addr <= '0;
            x        <= '0;
            y        <= '0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en)
                tag_q <= {x == '0 && y == '0, eol_x, eol_x && y == YW'(IMG_H - 1)};
            if (state == IDLE && state_nx == RUN) begin
                mem_addr <= '0;
                x        <= '0;
                y        <= '0;
            end else if (mem_rd_en) begin
                mem_addr <= mem_addr + 1'b1;
                x        <= eol_x ? '0 : x + 1'b1;
                if (eol_x)
                    y <= y + 1'b1;
            end
        end
    end

    skid_fifo2 u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .pop  (pop),
        .din  (din),
        .dout (head),
        .count(count)
    );
endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: directed checks of frame streaming on a 32x10 and a 4x3 instance
module tb_frame_streamer;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ready;
    logic       sel;
    int         total;
    int         bad;
    int         rd_cnt;

    logic       start_a, busy_a, done_a, rd_a;
    logic [8:0] addr_a;
    logic [7:0] rdata_a;
    logic       start_b, busy_b, done_b, rd_b;
    logic [3:0] addr_b;
    logic [7:0] rdata_b;

    logic       cvalid, cbusy, cdone, crd, csof, ceol, ceof;
    logic [7:0] cdata;
    logic [8:0] caddr;

    frame_streamer_if ia();
    frame_streamer_if ib();

    assign ia.ready = ready;
    assign ib.ready = ready;
    assign start_a  = start && !sel;
    assign start_b  = start && sel;

    assign cvalid = sel ? ib.valid : ia.valid;
    assign cdata  = sel ? ib.data  : ia.data;
    assign csof   = sel ? ib.sof   : ia.sof;
    assign ceol   = sel ? ib.eol   : ia.eol;
    assign ceof   = sel ? ib.eof   : ia.eof;
    assign cbusy  = sel ? busy_b   : busy_a;
    assign cdone  = sel ? done_b   : done_a;
    assign crd    = sel ? rd_b     : rd_a;
    assign caddr  = sel ? {5'd0, addr_b} : addr_a;

    frame_streamer #(.IMG_W(32), .IMG_H(10), .PIX_W(8), .ADDR_W(9)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rd_data(rdata_a), .m(ia)
    );

    frame_streamer #(.IMG_W(4), .IMG_H(3), .PIX_W(8), .ADDR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rd_data(rdata_b), .m(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ramp RAMs with one-cycle read latency
    always @(posedge clk) if (rd_a) rdata_a <= 8'(addr_a);
    always @(posedge clk) if (rd_b) rdata_b <= 8'hA0 + 8'(addr_b);
    always @(posedge clk) if (crd) rd_cnt <= rd_cnt + 1;

    // mode: 0 ready=1, 1 random ready, 2 restart at pixel 100, 3 stall 20 cycles, 4 start in done cycle
    task automatic run_frame(input int mode, input string tag);
        int k, cyc, stalls, held, n, w, rd0;
        bit fin, seen, ok_post;
        logic [7:0] ed;
        n = sel ? 12 : 320;
        w = sel ? 4 : 32;
        k = 0; cyc = 0; stalls = 0; held = 0; fin = 0; seen = 0;
        @(negedge clk);
        start = 1'b1; ready = 1'b1; rd0 = rd_cnt;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        total++;
        if ({cbusy, crd, caddr} !== {1'b1, 1'b1, 9'd0}) begin
            bad++;
            $display("FAIL %s issue: busy/rd_en/addr=%b/%b/%0d want 1/1/0", tag, cbusy, crd, caddr);
        end
        while (!fin && cyc < 4 * n + 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cdone === 1'b1) begin
                fin = 1;
                total++;
                if (cyc != 3 + n + stalls || k != n || cbusy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done: cycle=%0d pixels=%0d busy=%b want cycle=%0d pixels=%0d busy=0",
                             tag, cyc, k, cbusy, 3 + n + stalls, n);
                end
                if (mode == 4) start = 1'b1;
            end else if (cvalid === 1'b1) begin
                if (!seen) begin
                    seen = 1;
                    total++;
                    if (cyc != 3) begin
                        bad++;
                        $display("FAIL %s latency: first valid at cycle %0d want 3", tag, cyc);
                    end
                end
                ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 3 && held < 20) ? 1'b0 : 1'b1;
                if (mode == 3 && held < 20) begin
                    held++;
                    if (held == 20) begin
                        total++;
                        if (rd_cnt - rd0 > 2) begin
                            bad++;
                            $display("FAIL %s stall_reads: reads=%0d want <=2", tag, rd_cnt - rd0);
                        end
                    end
                end
                if (mode == 2 && k == 100) start = 1'b1;
                ed = sel ? 8'hA0 + 8'(k) : 8'(k);
                total++;
                if (k >= n || {cdata, csof, ceol, ceof} !== {ed, k == 0, (k % w) == w - 1, k == n - 1}) begin
                    bad++;
                    $display("FAIL %s pixel %0d: data/sof/eol/eof=%h/%b/%b/%b want %h/%b/%b/%b",
                             tag, k, cdata, csof, ceol, ceof, ed, k == 0, (k % w) == w - 1, k == n - 1);
                end
                if (ready) k++;
                else stalls++;
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done after %0d cycles, pixels=%0d want %0d", tag, cyc, k, n);
        end else begin
            ok_post = 1;
            repeat (4) begin
                @(negedge clk);
                start = 1'b0;
                if (cdone !== 1'b0 || cbusy !== 1'b0 || cvalid !== 1'b0) ok_post = 0;
            end
            total++;
            if (!ok_post) begin
                bad++;
                $display("FAIL %s idle_after: done/busy/valid=%b/%b/%b want 0/0/0", tag, cdone, cbusy, cvalid);
            end
        end
        ready = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({busy_a, done_a, rd_a, addr_a, ia.valid, ia.data, ia.sof, ia.eol, ia.eof} !== '0) begin
            bad++;
            $display("FAIL reset_a: outputs=%b want 0", {busy_a, done_a, rd_a, addr_a, ia.valid, ia.data, ia.sof, ia.eol, ia.eof});
        end
        total++;
        if ({busy_b, done_b, rd_b, addr_b, ib.valid, ib.data, ib.sof, ib.eol, ib.eof} !== '0) begin
            bad++;
            $display("FAIL reset_b: outputs=%b want 0", {busy_b, done_b, rd_b, addr_b, ib.valid, ib.data, ib.sof, ib.eol, ib.eof});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        sel = 1'b0;
        run_frame(0, "stream");
    endtask

    task automatic test_random_ready;
        sel = 1'b0;
        run_frame(1, "random_ready");
    endtask

    task automatic test_stall;
        sel = 1'b0;
        run_frame(3, "stall");
    endtask

    task automatic test_restart_ignored;
        sel = 1'b0;
        run_frame(2, "restart");
    endtask

    task automatic test_midframe_reset;
        sel = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (102) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy_a, done_a, rd_a, addr_a, ia.valid, ia.data, ia.sof, ia.eol, ia.eof} !== '0) begin
            bad++;
            $display("FAIL async_reset: outputs=%b want 0", {busy_a, done_a, rd_a, addr_a, ia.valid, ia.data, ia.sof, ia.eol, ia.eof});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, "after_reset");
    endtask

    task automatic test_small_frame;
        sel = 1'b1;
        run_frame(0, "small");
    endtask

    task automatic test_start_in_done;
        sel = 1'b1;
        run_frame(4, "start_in_done");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        sel   = 1'b0;
        total = 0;
        bad   = 0;
        test_reset;
        test_stream;
        test_random_ready;
        test_stall;
        test_restart_ignored;
        test_midframe_reset;
        test_small_frame;
        test_start_in_done;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_streamer.md
# frame_streamer

Reads one stored image frame (IMG_W x IMG_H pixels, raster order) from a synchronous pixel RAM and emits it as a valid/ready pixel stream with frame and line markers. It is the read-side counterpart of the frame loader that fills the RAM from a hex file, and it feeds the streaming image-processing pipeline one pixel per clock. Backpressure is fully supported with no pixel loss or duplication.

## Interface
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- PIX_W, 8, bits per pixel
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to stream a frame; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last pixel handshake
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address, y*IMG_W+x
- mem_rd_data  in  PIX_W  RAM data, valid exactly 1 cycle after mem_rd_en
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accept
- m_data  out  PIX_W  pixel value
- m_sof  out  1  pixel (0,0)
- m_eol  out  1  x == IMG_W-1
- m_eof  out  1  last pixel of frame

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: start=1 -> RUN; read address counter cleared to 0, x/y counters cleared.
- RUN: mem_rd_en asserted (combinational from state) when count + inflight - pop < 2, where count = FIFO occupancy, inflight = read issued last cycle, pop = m_valid & m_ready. Address increments by 1 per issued read; x wraps IMG_W-1 -> 0 with y++. After issuing address IMG_W*IMG_H-1 -> DRAIN.
- DRAIN: no reads; when FIFO empty and no read in flight -> IDLE, done pulses that same transition cycle's following cycle (done=1 for exactly one cycle, busy=0 in that cycle).
- Markers sof/eol/eof computed from x/y at issue time, delayed one cycle with the read, stored beside data in a 2-entry FIFO.
- Handshake: transfer when m_valid & m_ready. While m_valid & !m_ready, m_data and markers hold stable. m_valid never depends on m_ready.
- start during busy or during the done cycle: ignored.
- Reset (any time, including mid-frame): state IDLE, FIFO emptied, in-flight read discarded, counters 0.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, m_valid=0, m_data=0, m_sof=0, m_eol=0, m_eof=0.
- start high in cycle c -> mem_rd_en/addr 0 in c+1 -> data in FIFO at end of c+2 -> m_valid=1 with pixel 0 in c+3 (latency 3).
- With m_ready held 1: one pixel per cycle, last pixel in c+3+IMG_W*IMG_H-1, done in the next cycle.
- m_ready low for N cycles adds exactly N cycles to frame time; FIFO never overflows (max occupancy 2).

## Structure
- Package img_pkg: IMG_W, IMG_H, PIX_W defaults, pixel_t typedef, pix_tag_t packed struct {sof, eol, eof, data}, state enum.
- Sub-module skid_fifo2: 2-entry FIFO of pix_tag_t with push/pop/count, registered outputs.

## Test plan
- Ramp RAM (mem[i]=i[7:0]), m_ready=1, start once -> 76800 pixels, m_data sequence 00..FF repeating, sof only on first, eol on every 320th, eof only on last, done at c+3+76800.
- Random m_ready (50%) -> identical output sequence, no gap/duplicate, done one cycle after final handshake.
- m_ready held 0 for 20 cycles after first m_valid -> pixel 0 stable all 20 cycles, at most 2 reads issued, streaming resumes with pixel 1.
- start pulsed again at pixel 100 -> ignored, exactly one frame emitted.
- rst_n asserted at pixel 5000 -> all outputs 0 asynchronously; new start afterwards streams from address 0 with sof.
- Small config IMG_W=4, IMG_H=3 -> 12 pixels, eol at x=3 on each line, eof on pixel 11.
